// File: rtl/serial_word_adder.sv
// Bit-serial LSB-first add/subtract unit with a per-word overflow/borrow flag and a bit-position output.
// Optional build macro SERIAL_ADDER_SIGNED_EN: the word flag reports two's-complement signed overflow instead.
module serial_word_adder #(
    parameter int WORD_LEN = 4,
    localparam int IDX_W = (WORD_LEN <= 2) ? 1 : $clog2(WORD_LEN)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             en,
    input  logic             mode,
    input  logic             line1,
    input  logic             line2,
    output logic             outp,
    output logic             overflw,
    output logic             word_end,
    output logic [IDX_W-1:0] bit_idx
);

    typedef enum logic [1:0] {FIRST, MID, LAST} state_t;

    localparam logic [IDX_W-1:0] PENULT_IDX = IDX_W'(WORD_LEN - 2);

    state_t           state_reg, state_next;
    logic [IDX_W-1:0] cnt_reg, cnt_next;
    logic             carry_reg, carry_next;
    logic             mode_q_reg, mode_q_next;
    logic             outp_reg, outp_next;
    logic             overflw_reg, overflw_next;
    logic             word_end_reg, word_end_next;
    logic [IDX_W-1:0] bit_idx_reg, bit_idx_next;

    logic m, b, c_in, sum, c_out;

    // Bit 0 takes the live mode; subtraction is A + ~B + 1, so the inverted
    // operand and the initial carry-in both come from the mode bit.
    always_comb begin
        m     = (state_reg == FIRST) ? mode : mode_q_reg;
        b     = line2 ^ m;
        c_in  = (state_reg == FIRST) ? m : carry_reg;
        sum   = line1 ^ b ^ c_in;
        c_out = (line1 & b) | (line1 & c_in) | (b & c_in);
    end

    always_comb begin
        state_next    = state_reg;
        cnt_next      = cnt_reg;
        carry_next    = carry_reg;
        mode_q_next   = mode_q_reg;
        outp_next     = outp_reg;
        overflw_next  = overflw_reg;
        word_end_next = word_end_reg;
        bit_idx_next  = bit_idx_reg;
        if (en) begin
            outp_next     = sum;
            carry_next    = c_out;
            bit_idx_next  = cnt_reg;
            overflw_next  = 1'b0;
            word_end_next = 1'b0;
            case (state_reg)
                FIRST: begin
                    mode_q_next = mode;
                    cnt_next    = cnt_reg + 1'b1;
                    state_next  = (WORD_LEN == 2) ? LAST : MID;
                end
                MID: begin
                    cnt_next   = cnt_reg + 1'b1;
                    state_next = (cnt_reg < PENULT_IDX) ? MID : LAST;
                end
                LAST: begin
                    cnt_next      = '0;
                    state_next    = FIRST;
                    word_end_next = 1'b1;
`ifdef SERIAL_ADDER_SIGNED_EN
                    overflw_next  = c_in ^ c_out;
`else
                    overflw_next  = m ? ~c_out : c_out;
`endif
                end
                default: begin
                    cnt_next   = '0;
                    state_next = FIRST;
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg    <= FIRST;
            cnt_reg      <= '0;
            carry_reg    <= 1'b0;
            mode_q_reg   <= 1'b0;
            outp_reg     <= 1'b0;
            overflw_reg  <= 1'b0;
            word_end_reg <= 1'b0;
            bit_idx_reg  <= '0;
        end else begin
            state_reg    <= state_next;
            cnt_reg      <= cnt_next;
            carry_reg    <= carry_next;
            mode_q_reg   <= mode_q_next;
            outp_reg     <= outp_next;
            overflw_reg  <= overflw_next;
            word_end_reg <= word_end_next;
            bit_idx_reg  <= bit_idx_next;
        end
    end

    assign outp     = outp_reg;
    assign overflw  = overflw_reg;
    assign word_end = word_end_reg;
    assign bit_idx  = bit_idx_reg;

endmodule
